// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Raster timing generator for the VGA pixel path. Two free-running counters
// (hcnt/vcnt) walk the H_TOTAL x V_TOTAL raster, one pixel per pel_en tick.
// The counter position is decoded and registered, so the outputs on the clock
// after a tick describe the pixel the counters held at that tick.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   pel_en       pixel tick; nothing advances or changes while low
//   x, y         coordinates of the pixel currently presented
//   active       pixel lies inside the visible window
//   vga_hs/vs    horizontal / vertical sync, asserted level = SYNC_POL
//   vga_blank    DAC blank, same as active
//   vga_sync     DAC composite sync, constant 0
//   line_start   high for the whole pixel period of x==0
//   frame_start  high for the whole pixel period of x==0, y==0
//
// Build option:
//   VGA_TIMING_PIPE_EN  when defined, sync/active/blank/strobes are delayed by
//                       PIPE_DEPTH further pel_en-clocked stages to line up
//                       with the background/sprite ROM read latency. x and y
//                       are never delayed. When undefined PIPE_DEPTH is unused.
//
// H_TOTAL and V_TOTAL must each be <= 1024 (10-bit counters).
// ---------------------------------------------------------------------------
module vga_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0,
   parameter int PIPE_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pel_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank,
   output logic       vga_sync,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // Window bounds kept at 11 bits so a sync pulse ending exactly at 1024
   // still compares correctly against the 10-bit counters.
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
   } tim_t;

   localparam tim_t TIM_RST = '{active: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL,
                                ls: 1'b0, fs: 1'b0};

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   tim_t       tim_q, tim_d;
   tim_t       tim_out;

   logic [10:0] h_ext;
   logic [10:0] v_ext;

   assign h_ext = {1'b0, hcnt_q};
   assign v_ext = {1'b0, vcnt_q};

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      x_d    = x_q;
      y_d    = y_q;
      tim_d  = tim_q;
      if (pel_en) begin
         x_d          = hcnt_q;
         y_d          = vcnt_q;
         tim_d.active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
         tim_d.hs     = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END))
                        ? SYNC_POL : ~SYNC_POL;
         tim_d.vs     = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END))
                        ? SYNC_POL : ~SYNC_POL;
         tim_d.ls     = (hcnt_q == 10'd0);
         tim_d.fs     = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

         if (hcnt_q == H_LAST) begin
            hcnt_d = 10'd0;
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q <= 10'd0;
         vcnt_q <= 10'd0;
         x_q    <= 10'd0;
         y_q    <= 10'd0;
         tim_q  <= TIM_RST;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         x_q    <= x_d;
         y_q    <= y_d;
         tim_q  <= tim_d;
      end
   end

`ifdef VGA_TIMING_PIPE_EN
   generate
      if (PIPE_DEPTH > 0) begin : g_pipe
         tim_t [PIPE_DEPTH-1:0] pipe_q, pipe_d;

         // Shift only on pixel ticks so the delay is measured in pixels,
         // not clocks, and strobes keep their one-pixel width.
         always_comb begin
            pipe_d = pipe_q;
            if (pel_en) begin
               pipe_d[0] = tim_q;
               for (int i = 1; i < PIPE_DEPTH; i++) begin
                  pipe_d[i] = pipe_q[i-1];
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe_q <= {PIPE_DEPTH{TIM_RST}};
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign tim_out = pipe_q[PIPE_DEPTH-1];
      end else begin : g_no_pipe
         assign tim_out = tim_q;
      end
   endgenerate
`else
   localparam int unused_pipe_depth = PIPE_DEPTH;
   assign tim_out = tim_q;
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign active      = tim_out.active;
   assign vga_blank   = tim_out.active;
   assign vga_hs      = tim_out.hs;
   assign vga_vs      = tim_out.vs;
   assign line_start  = tim_out.ls;
   assign frame_start = tim_out.fs;
   assign vga_sync    = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// u_dut runs the default 640x480 timing for reset, first-pixel, line-level and
// pel_en gating checks. u_sml uses a tiny 15x10 raster so whole-frame counts
// and a mid-frame reset can be exercised in a few hundred cycles.
// Expectations assume the default build (no extra pipe stages).
// ---------------------------------------------------------------------------
module tb_vga_timing;

   logic       clk;
   logic       rst_d, pel_en_d;
   logic [9:0] x_d, y_d;
   logic       act_d, hs_d, vs_d, blank_d, sync_d, ls_d, fs_d;

   logic       rst_s, pel_en_s;
   logic [9:0] x_s, y_s;
   logic       act_s, hs_s, vs_s, blank_s, sync_s, ls_s, fs_s;

   int n_checks = 0;
   int n_errors = 0;

   vga_timing u_dut (
      .clk(clk), .rst(rst_d), .pel_en(pel_en_d),
      .x(x_d), .y(y_d), .active(act_d),
      .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank(blank_d), .vga_sync(sync_d),
      .line_start(ls_d), .frame_start(fs_d)
   );

   // 15 x 10 raster: H = 8+2+3+2, V = 6+1+2+1
   vga_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_sml (
      .clk(clk), .rst(rst_s), .pel_en(pel_en_s),
      .x(x_s), .y(y_s), .active(act_s),
      .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank(blank_s), .vga_sync(sync_s),
      .line_start(ls_s), .frame_start(fs_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive pel_en for the next edge, then sample 1 time unit after it.
   task automatic tick_d(input logic en);
      pel_en_d = en;
      @(posedge clk);
      #1;
   endtask

   task automatic tick_s(input logic en);
      pel_en_s = en;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_d(input string tag);
      chk({tag, "_x"},     32'(x_d), 0);
      chk({tag, "_y"},     32'(y_d), 0);
      chk({tag, "_act"},   32'(act_d), 0);
      chk({tag, "_hs"},    32'(hs_d), 1);
      chk({tag, "_vs"},    32'(vs_d), 1);
      chk({tag, "_blank"}, 32'(blank_d), 0);
      chk({tag, "_sync"},  32'(sync_d), 0);
      chk({tag, "_ls"},    32'(ls_d), 0);
      chk({tag, "_fs"},    32'(fs_d), 0);
   endtask

   typedef struct {
      int         ticks;   // pel_en ticks since reset release
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int t;
      int hs_low, act_cnt, win_err, tog_err;
      int s_act, s_ls, s_hs, s_vs, s_mis, fs_first, fs_second;
      logic [9:0] hold_x;

      vecs[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{641,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{656,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{657,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{752,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{753,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{800,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1441, 10'd640, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_d = 1'b0; pel_en_d = 1'b0;
      rst_s = 1'b0; pel_en_s = 1'b0;
      #1;
      rst_d = 1'b1; rst_s = 1'b1;
      #2;
      chk_reset_d("rst0");

      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_d = 1'b0;

      // --- table-driven walk along line 0 / line 1 ---
      t = 0;
      for (int i = 0; i < 11; i++) begin
         while (t < vecs[i].ticks) begin
            tick_d(1'b1);
            t++;
         end
         chk($sformatf("vec%0d", i),
             32'({x_d, y_d, act_d, hs_d, vs_d, ls_d, fs_d}),
             32'({vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].hs,
                  vecs[i].vs, vecs[i].ls, vecs[i].fs}));
         chk($sformatf("vec%0d_blank", i), 32'(blank_d), 32'(vecs[i].act));
      end

      // --- full line y=2: hs window and active width ---
      while (t < 1600) begin
         tick_d(1'b1);
         t++;
      end
      hs_low = 0; act_cnt = 0; win_err = 0;
      for (int i = 0; i < 800; i++) begin
         tick_d(1'b1);
         if (hs_d == 1'b0) hs_low++;
         if (act_d) act_cnt++;
         if (x_d !== 10'(i) || y_d !== 10'd2 ||
             hs_d !== !(i >= 656 && i < 752) || vs_d !== 1'b1 ||
             act_d !== (i < 640) || ls_d !== (i == 0) || fs_d !== 1'b0)
            win_err++;
      end
      chk("line_hs_low_ticks", 32'(hs_low), 96);
      chk("line_active_ticks", 32'(act_cnt), 640);
      chk("line_decode_errs", 32'(win_err), 0);

      // --- pel_en gating: tick every other clock ---
      pel_en_d = 1'b0;
      rst_d = 1'b1;
      #1;
      chk_reset_d("rst1");
      @(posedge clk); #1;
      rst_d = 1'b0;
      tog_err = 0;
      for (int k = 0; k < 6; k++) begin
         tick_d(1'b1);
         if (x_d !== 10'(k) || ls_d !== (k == 0) || fs_d !== (k == 0))
            tog_err++;
         hold_x = x_d;
         tick_d(1'b0);
         if (k == 0) begin
            chk("hold_ls_2clk", 32'(ls_d), 1);
            chk("hold_fs_2clk", 32'(fs_d), 1);
         end
         if (x_d !== hold_x || ls_d !== (k == 0) || fs_d !== (k == 0) ||
             act_d !== 1'b1 || hs_d !== 1'b1)
            tog_err++;
      end
      chk("toggle_errs", 32'(tog_err), 0);
      chk("toggle_final_x", 32'(x_d), 5);

      // --- small raster: whole-frame counts ---
      rst_s = 1'b0;
      s_act = 0; s_ls = 0; s_hs = 0; s_vs = 0; s_mis = 0;
      fs_first = -1; fs_second = -1;
      for (int i = 0; i < 301; i++) begin
         int h, v;
         tick_s(1'b1);
         h = i % 15;
         v = (i / 15) % 10;
         if (i < 150) begin
            if (act_s) s_act++;
            if (ls_s) s_ls++;
            if (!hs_s) s_hs++;
            if (!vs_s) s_vs++;
         end
         if (fs_s) begin
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
         if (x_s !== 10'(h) || y_s !== 10'(v) ||
             act_s !== (h < 8 && v < 6) ||
             hs_s !== !(h >= 10 && h < 13) ||
             vs_s !== !(v >= 7 && v < 9) ||
             blank_s !== act_s || sync_s !== 1'b0)
            s_mis++;
      end
      chk("sml_active_ticks", 32'(s_act), 48);
      chk("sml_line_starts", 32'(s_ls), 10);
      chk("sml_hs_low_ticks", 32'(s_hs), 30);
      chk("sml_vs_low_ticks", 32'(s_vs), 30);
      chk("sml_fs_first", 32'(fs_first), 0);
      chk("sml_fs_period", 32'(fs_second - fs_first), 150);
      chk("sml_decode_errs", 32'(s_mis), 0);

      // --- small raster: reset mid-frame at (5,4) without a clock edge ---
      for (int i = 0; i < 65; i++) tick_s(1'b1);
      chk("sml_pre_rst_xy", 32'({x_s, y_s}), 32'({10'd5, 10'd4}));
      #3;
      rst_s = 1'b1;
      #1;
      chk("sml_async_xy", 32'({x_s, y_s}), 0);
      chk("sml_async_flags", 32'({act_s, hs_s, vs_s, ls_s, fs_s}),
          32'(5'b01100));
      @(posedge clk); #1;
      rst_s = 1'b0;
      tick_s(1'b1);
      chk("sml_restart_pix", 32'({x_s, y_s, act_s, ls_s, fs_s}),
          32'({10'd0, 10'd0, 3'b111}));
      tick_s(1'b1);
      chk("sml_restart_next", 32'({x_s, y_s, fs_s}),
          32'({10'd1, 10'd0, 1'b0}));
      pel_en_s = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
